// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundle between the multicycle control FSM and its datapath.
//
//   Handshake: the datapath presents mem_ready. When the controller issues a
//   request (mem_read in FETCH/MEM_RD, mem_write in MEM_WR), the request stays
//   asserted every cycle until a cycle in which mem_ready=1. That cycle
//   completes the access and the FSM leaves the state on the following edge.
//   With MEM_HANDSHAKE=0 every request completes in its first cycle.
//
//   Signals (controller view):
//     opcode      in   instruction[31:26] from the IR, sampled in DECODE
//     mem_ready   in   memory completes the access this cycle
//     pc_write .. pc_source   out  datapath enables and mux selects
//     illegal_op  out  sticky trap flag
//     state_o     out  current FSM state encoding (debug)
//
//   modport master : the control unit
//   modport slave  : the datapath / testbench side
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic [3:0]         state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   Moore FSM sequencing fetch / decode / execute / memory / write-back for
//   the MIPS subset R-type, lw, sw, beq, j, addi. Unsupported opcodes trap
//   until reset.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   multicycle_control_unit_if.master (opcode, mem_ready in;
//           datapath enables, illegal_op, state_o out)
//
//   Parameters:
//     OP_W          opcode width; opcodes compared zero-extended
//     ALUOP_W       alu_op width (00 add, 01 sub, 10 funct-decode)
//     MEM_HANDSHAKE 1: memory states wait for mem_ready, 0: single cycle
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OP_W          = 6,
  parameter int ALUOP_W       = 2,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.master   bus
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd15;

  // Opcodes are compared at the wider of OP_W and 6 bits so a narrow opcode
  // never aliases onto a 6-bit constant by truncation.
  localparam int CMP_W = (OP_W > 6) ? OP_W : 6;

  function automatic logic op_is(input logic [OP_W-1:0] op, input logic [5:0] code);
    return CMP_W'(op) == CMP_W'(code);
  endfunction

  logic [3:0]      state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;
  logic            mem_done;
  logic [3:0]      out_state;

  assign mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        if (op_is(bus.opcode, 6'h00))                                  state_d = S_R_EXEC;
        else if (op_is(bus.opcode, 6'h23) || op_is(bus.opcode, 6'h2B)) state_d = S_MEM_ADDR;
        else if (op_is(bus.opcode, 6'h04))                             state_d = S_BRANCH;
        else if (op_is(bus.opcode, 6'h02))                             state_d = S_JUMP;
        else if (op_is(bus.opcode, 6'h08))                             state_d = S_ADDI_EXEC;
        else                                                           state_d = S_TRAP;
      end
      // Load/store split uses the opcode captured in DECODE, not the live one.
      S_MEM_ADDR:  state_d = op_is(op_q, 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_done) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_done) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;   // encodings 12..14 are unreachable
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
      // Set on the edge entering TRAP so the flag is visible in its first cycle.
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // ---------------- Moore outputs ----------------
  // During reset the non-enable outputs show FETCH values; every write and
  // request is then forced low so a reset mid-instruction writes nothing.
  assign out_state = rst ? S_FETCH : state_q;

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = '0;
    bus.pc_source     = 2'b00;
    case (out_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC load only in the cycle the fetch actually completes.
        bus.ir_write  = mem_done;
        bus.pc_write  = mem_done;
      end
      S_DECODE:    bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_W'(2'b10);
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_W'(2'b01);
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   bus.reg_write = 1'b1;
      default: ;   // TRAP and unreachable encodings drive everything low
    endcase
    if (rst) begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
    end
  end

  assign bus.illegal_op = illegal_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Two instances: u_dut0 with MEM_HANDSHAKE=0, u_dut1 with MEM_HANDSHAKE=1.
//   Each test builds the expected per-cycle state trace of whole instructions
//   (from the instruction classes and their memory wait cycles) into exp_q,
//   then replays it: inputs are driven on the falling edge, outputs are
//   sampled 1 time unit later and compared against the per-state control
//   table.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [2];
  logic [5:0] op_v  [2];
  logic       rdy_v [2];

  multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(2)) bus0 ();
  multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(2)) bus1 ();

  assign bus0.opcode    = op_v[0];
  assign bus0.mem_ready = rdy_v[0];
  assign bus1.opcode    = op_v[1];
  assign bus1.mem_ready = rdy_v[1];

  multicycle_control_unit #(.OP_W(6), .ALUOP_W(2), .MEM_HANDSHAKE(1'b0)) u_dut0 (
    .clk (clk), .rst (rst_v[0]), .bus (bus0)
  );
  multicycle_control_unit #(.OP_W(6), .ALUOP_W(2), .MEM_HANDSHAKE(1'b1)) u_dut1 (
    .clk (clk), .rst (rst_v[1]), .bus (bus1)
  );

  // Observed outputs packed as {pc_write, pc_write_cond, i_or_d, mem_read,
  // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
  // alu_src_b[1:0], alu_op[1:0], pc_source[1:0]}.
  logic [15:0] ctrl_obs [2];
  logic [3:0]  st_obs   [2];
  logic        ill_obs  [2];

  always_comb begin
    ctrl_obs[0] = {bus0.pc_write, bus0.pc_write_cond, bus0.i_or_d, bus0.mem_read,
                   bus0.mem_write, bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst,
                   bus0.reg_write, bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op,
                   bus0.pc_source};
    ctrl_obs[1] = {bus1.pc_write, bus1.pc_write_cond, bus1.i_or_d, bus1.mem_read,
                   bus1.mem_write, bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst,
                   bus1.reg_write, bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op,
                   bus1.pc_source};
    st_obs[0]  = bus0.state_o;
    st_obs[1]  = bus1.state_o;
    ill_obs[0] = bus0.illegal_op;
    ill_obs[1] = bus1.illegal_op;
  end

  // Write/request bits: pc_write, pc_write_cond, mem_read, mem_write,
  // ir_write, reg_write.
  localparam logic [15:0] EN_MASK = 16'b1101_1100_1000_0000;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // Entry: {opcode[5:0], mem_ready, state[3:0]}
  logic [10:0] exp_q[$];

  // Reference control table: what each named step of the instruction cycle
  // asks of the datapath.
  function automatic logic [15:0] exp_ctrl(input int s, input logic rdy, input bit hs);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (s)
      0:  begin mr = 1; asb = 2'd1; irw = hs ? rdy : 1'b1; pw = irw; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
      9:  begin pw = 1; psrc = 2'd2; end
      10: begin asa = 1; asb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  function automatic logic [10:0] ent(input logic [5:0] op, input logic rdy, input int s);
    return {op, rdy, 4'(s)};
  endfunction

  // A memory step: with handshake, `waits` not-ready cycles then a ready one;
  // without handshake exactly one cycle with mem_ready at random.
  task automatic push_mem(input logic [5:0] op, input int s, input int waits, input bit hs);
    if (hs) begin
      repeat (waits) exp_q.push_back(ent(op, 1'b0, s));
      exp_q.push_back(ent(op, 1'b1, s));
    end else begin
      exp_q.push_back(ent(op, 1'($urandom_range(0, 1)), s));
    end
  endtask

  // Expected trace of one instruction, from FETCH to its last state.
  task automatic queue_instr(input bit hs, input logic [5:0] op, input int fw, input int mw);
    push_mem(op, 0, fw, hs);
    exp_q.push_back(ent(op, 1'($urandom_range(0, 1)), 1));
    case (op)
      6'h00: begin exp_q.push_back(ent(op, 1'b0, 6)); exp_q.push_back(ent(op, 1'b1, 7)); end
      6'h23: begin exp_q.push_back(ent(op, 1'b0, 2)); push_mem(op, 3, mw, hs);
                   exp_q.push_back(ent(op, 1'b1, 4)); end
      6'h2B: begin exp_q.push_back(ent(op, 1'b1, 2)); push_mem(op, 5, mw, hs); end
      6'h04: exp_q.push_back(ent(op, 1'b0, 8));
      6'h02: exp_q.push_back(ent(op, 1'b1, 9));
      6'h08: begin exp_q.push_back(ent(op, 1'b0, 10)); exp_q.push_back(ent(op, 1'b1, 11)); end
      default: exp_q.push_back(ent(op, 1'b0, 15));
    endcase
  endtask

  // ---------------- driver / checker ----------------
  // One cycle per queue entry. The opcode is only meaningful in DECODE; in
  // every other cycle a random opcode is driven to show it is ignored there.
  task automatic run_queue(input int d, input string tag);
    int cyc;
    logic [10:0] e;
    logic [15:0] want;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      rst_v[d] = 1'b0;
      rdy_v[d] = e[4];
      op_v[d]  = (e[3:0] == 4'd1) ? e[10:5] : 6'($urandom);
      #1;
      want = exp_ctrl(int'(e[3:0]), e[4], d == 1);
      n_cmp++;
      if (st_obs[d] !== e[3:0]) begin
        n_bad++;
        $display("FAIL %s dut%0d cyc%0d state: got %0d want %0d", tag, d, cyc, st_obs[d], e[3:0]);
      end
      n_cmp++;
      if (ctrl_obs[d] !== want) begin
        n_bad++;
        $display("FAIL %s dut%0d cyc%0d ctrl (state %0d): got %b want %b",
                 tag, d, cyc, e[3:0], ctrl_obs[d], want);
      end
      n_cmp++;
      if (ill_obs[d] !== (e[3:0] == 4'd15)) begin
        n_bad++;
        $display("FAIL %s dut%0d cyc%0d illegal_op: got %b want %b",
                 tag, d, cyc, ill_obs[d], e[3:0] == 4'd15);
      end
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  // Two reset edges. The request/write outputs must drop in the very cycle
  // rst rises; after the edge the FSM shows FETCH with illegal_op clear.
  // rst is left high; the next run_queue releases it.
  task automatic test_reset(input int d);
    logic [15:0] want;
    @(negedge clk);
    rst_v[d] = 1'b1;
    rdy_v[d] = 1'($urandom_range(0, 1));
    op_v[d]  = 6'($urandom);
    #1;
    n_cmp++;
    if ((ctrl_obs[d] & EN_MASK) !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_gate dut%0d enables: got %b want 0", d, ctrl_obs[d] & EN_MASK);
    end
    repeat (2) begin
      @(negedge clk);
      rdy_v[d] = 1'($urandom_range(0, 1));
      op_v[d]  = 6'($urandom);
      #1;
      want = exp_ctrl(0, rdy_v[d], d == 1) & ~EN_MASK;
      n_cmp++;
      if (st_obs[d] !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %0d want 0", d, st_obs[d]);
      end
      n_cmp++;
      if (ill_obs[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_illegal dut%0d: got %b want 0", d, ill_obs[d]);
      end
      n_cmp++;
      if (ctrl_obs[d] !== want) begin
        n_bad++;
        $display("FAIL reset_ctrl dut%0d: got %b want %b", d, ctrl_obs[d], want);
      end
    end
  endtask

  task automatic test_r_type();
    test_reset(0);
    queue_instr(1'b0, 6'h00, 0, 0);
    exp_q.push_back(ent(6'h00, 1'b0, 0));   // back in FETCH after 4 cycles
    run_queue(0, "r_type");
  endtask

  // lw with 3 not-ready cycles in FETCH and 2 in MEM_RD: 10 cycles in total.
  task automatic test_lw_wait();
    test_reset(1);
    queue_instr(1'b1, 6'h23, 3, 2);
    exp_q.push_back(ent(6'h00, 1'b0, 0));
    run_queue(1, "lw_wait");
  endtask

  task automatic test_sw_hold();
    test_reset(1);
    queue_instr(1'b1, 6'h2B, int'($urandom_range(0, 2)), int'($urandom_range(1, 4)));
    queue_instr(1'b1, 6'h2B, 0, 0);
    exp_q.push_back(ent(6'h00, 1'b0, 0));
    run_queue(1, "sw_hold");
  endtask

  task automatic test_back_to_back(input int d);
    logic [5:0] legal [6];
    logic [5:0] op;
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    test_reset(d);
    queue_instr(d == 1, 6'h04, 0, 0);
    queue_instr(d == 1, 6'h02, 0, 0);
    queue_instr(d == 1, 6'h08, 0, 0);
    for (int i = 0; i < 16; i++) begin
      op = legal[$urandom_range(0, 5)];
      queue_instr(d == 1, op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    exp_q.push_back(ent(6'h00, 1'b0, 0));
    run_queue(d, "back_to_back");
  endtask

  // Illegal opcode traps after DECODE and stays there with everything low.
  task automatic test_trap(input int d, input logic [5:0] op);
    test_reset(d);
    queue_instr(d == 1, op, int'($urandom_range(0, 2)), 0);
    repeat (20) exp_q.push_back(ent(op, 1'($urandom_range(0, 1)), 15));
    run_queue(d, "trap");
    test_reset(d);
    queue_instr(d == 1, 6'h00, 0, 0);
    run_queue(d, "after_trap");
  endtask

  // Reset while a store is stalled in MEM_WR.
  task automatic test_reset_mid();
    test_reset(1);
    exp_q.push_back(ent(6'h2B, 1'b1, 0));
    exp_q.push_back(ent(6'h2B, 1'b0, 1));
    exp_q.push_back(ent(6'h2B, 1'b0, 2));
    repeat (3) exp_q.push_back(ent(6'h2B, 1'b0, 5));
    run_queue(1, "reset_mid");
    test_reset(1);
    queue_instr(1'b1, 6'h00, 0, 0);
    run_queue(1, "after_reset_mid");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    logic [5:0] bad_op;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    op_v[0]  = 6'd0; op_v[1]  = 6'd0;
    rdy_v[0] = 1'b0; rdy_v[1] = 1'b0;

    test_reset(0);
    test_reset(1);
    test_r_type();
    test_lw_wait();
    test_sw_hold();
    test_back_to_back(0);
    test_back_to_back(1);
    test_trap(0, 6'h3F);
    // random unsupported opcode
    do bad_op = 6'($urandom);
    while (bad_op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
    test_trap(1, bad_op);
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
